// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Default widths, reset PC and the fetch bundle type.
package cpu_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic [ADDR_W_DEF-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_t;
endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch FIFO.
// Synchronous flush, occupancy count output.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push = push && (cnt_q != CW'(DEPTH));
    do_pop  = pop && (cnt_q != '0);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: PC, imem issue, kill on redirect,
// prefetch buffer and valid/ready delivery to the core.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] iss_q, iss_d;
  logic              infl_q, infl_d;
  logic              kill_q, kill_d;
  logic [CW-1:0]     count;
  logic [W-1:0]      head;
  logic [CW:0]       occ;
  logic              pop;
  logic              push;

  assign instr_valid = (count != '0);
  assign instr_pc    = head[W-1:DATA_W];
  assign instr_data  = head[DATA_W-1:0];
  assign imem_addr   = pc_q;
  assign busy        = infl_q || instr_valid;

  // A head leaving this cycle frees its slot for the next issue,
  // which keeps one-per-cycle streaming without ever overflowing.
  always_comb begin
    pop  = instr_valid && instr_ready;
    occ  = {1'b0, count} + (CW+1)'(infl_q) - (CW+1)'(pop);
    imem_rd_en = rst_n && !halt && !redirect_valid &&
                 (occ < (CW+1)'(DEPTH));
    push   = infl_q && !kill_q;
    infl_d = imem_rd_en;
    kill_d = redirect_valid;
    iss_d  = imem_rd_en ? pc_q : iss_q;
    unique case (1'b1)
      redirect_valid: pc_d = redirect_pc;
      imem_rd_en:     pc_d = pc_q + ADDR_W'(1);
      default:        pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= ADDR_W'(RESET_PC);
      iss_q  <= '0;
      infl_q <= 1'b0;
      kill_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      iss_q  <= iss_d;
      infl_q <= infl_d;
      kill_q <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({iss_q, imem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );
endmodule
